// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : seq_multiplier
// Description : Iterative radix-2 Booth signed multiplier. One Booth step per
//               clock, start/done handshake, registered 2*WIDTH-bit product
//               that is held stable between completions.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     mul1,
  input  logic [WIDTH-1:0]     mul2,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   mulresult
);

  // Step counter only needs to reach WIDTH-1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] c_LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  // Multiplicand and accumulator carry one extra bit so that
  // A - M cannot overflow when M is the most negative value.
  logic [WIDTH:0]       m_q, m_d;
  logic [WIDTH:0]       a_q, a_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic                 qm1_q, qm1_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // Combinational result of one Booth step on the current register state.
  logic [WIDTH:0]       booth_sum;
  logic [WIDTH:0]       step_a;
  logic [WIDTH-1:0]     step_q;
  logic                 step_qm1;

  // One Booth add/subtract followed by an arithmetic right shift of {A,Q,q-1}.
  always_comb begin
    booth_sum = a_q;
    unique case ({q_q[0], qm1_q})
      2'b10:   booth_sum = a_q - m_q;
      2'b01:   booth_sum = a_q + m_q;
      default: booth_sum = a_q;
    endcase
    step_a   = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    step_q   = {booth_sum[0], q_q[WIDTH-1:1]};
    step_qm1 = q_q[0];
  end

  // Next-state and datapath control; everything defaults to holding.
  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    a_d      = a_q;
    q_d      = q_q;
    qm1_d    = qm1_q;
    count_d  = count_q;
    result_d = result_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          // Operands are captured here; later input changes are ignored.
          m_d     = {mul1[WIDTH-1], mul1};
          a_d     = '0;
          q_d     = mul2;
          qm1_d   = 1'b0;
          count_d = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        a_d     = step_a;
        q_d     = step_q;
        qm1_d   = step_qm1;
        count_d = count_q + 1'b1;
        if (count_q == c_LAST_STEP) begin
          // The exact product always fits in 2*WIDTH bits, so the extra
          // accumulator sign bit is dropped.
          result_d = {step_a[WIDTH-1:0], step_q};
          count_d  = '0;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end else begin
          busy_d   = 1'b1;
        end
      end

      S_DONE: begin
        // Start is not sampled here; it is only looked at in IDLE.
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any multiply in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      m_q      <= '0;
      a_q      <= '0;
      q_q      <= '0;
      qm1_q    <= 1'b0;
      count_q  <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      a_q      <= a_d;
      q_q      <= q_d;
      qm1_q    <= qm1_d;
      count_q  <= count_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mulresult = result_q;

endmodule
`default_nettype wire
